// File: rtl/hi_lo_unit.sv
// hi_lo_unit: EX-stage multiply/divide unit owning the architectural HI/LO
// registers. Multiplies finish in the accept cycle; divides run a radix-2
// restoring algorithm for DIV_CYCLES iterations and stall EX through in_ready.
module hi_lo_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  hi_lo_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        div_done,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES - 1);

    state_t      state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        qneg_q;
    logic        rneg_q;

    logic [7:0]  opSel;
    logic        accept;
    logic        signedDiv;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [32:0] remShift;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] remNext;
    logic [31:0] quoNext;
    logic [31:0] quoFinal;
    logic [31:0] remFinal;

    // Lowest set bit of the op field wins when decode hands us a multi-hot value.
    assign opSel  = hi_lo_op & (~hi_lo_op + 8'd1);
    assign accept = in_valid & in_ready & ~flush & (|hi_lo_op);

    // Divide operand preparation: magnitudes for div, raw values for divu.
    assign signedDiv = opSel[0];
    assign absA = (signedDiv && src1[31]) ? (~src1 + 32'd1) : src1;
    assign absB = (signedDiv && src2[31]) ? (~src2 + 32'd1) : src2;

    // Full 64-bit products; only the low 64 bits of each are meaningful.
    assign prodS = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
    assign prodU = {32'd0, src1} * {32'd0, src2};

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign remShift = {rem_q, quo_q[31]};
    assign diff     = remShift - {1'b0, dvs_q};
    assign fits     = ~diff[32];
    assign remNext  = fits ? diff[31:0] : remShift[31:0];
    assign quoNext  = {quo_q[30:0], fits};
    assign quoFinal = qneg_q ? (~quoNext + 32'd1) : quoNext;
    assign remFinal = rneg_q ? (~remNext + 32'd1) : remNext;

    assign in_ready = (state_q != S_DIV);
    assign busy     = busy_q;
    assign div_done = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // mfhi/mflo read port: current register value whenever a move-from is presented.
    always_comb begin
        rdata = 32'd0;
        if (in_valid && opSel[6]) begin
            rdata = hi_q;
        end else if (in_valid && opSel[7]) begin
            rdata = lo_q;
        end
    end

    // Control FSM plus HI/LO and divider datapath; flush beats every accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_DIV: begin
                    rem_q <= remNext;
                    quo_q <= quoNext;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        hi_q    <= remFinal;
                        lo_q    <= quoFinal;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (accept) begin
                        if (opSel[0] || opSel[1]) begin
                            // Divide by zero keeps an unsigned all-ones quotient.
                            quo_q   <= absA;
                            dvs_q   <= absB;
                            rem_q   <= 32'd0;
                            cnt_q   <= 6'd0;
                            qneg_q  <= signedDiv & (src1[31] ^ src2[31]) & (|src2);
                            rneg_q  <= signedDiv & src1[31];
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                        end else if (opSel[2]) begin
                            hi_q <= prodS[63:32];
                            lo_q <= prodS[31:0];
                        end else if (opSel[3]) begin
                            hi_q <= prodU[63:32];
                            lo_q <= prodU[31:0];
                        end else if (opSel[4]) begin
                            hi_q <= src1;
                        end else if (opSel[5]) begin
                            lo_q <= src1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/hi_lo_unit.md
Name: hi_lo_unit

Overview:
- EX-stage multiply/divide unit. Consumes the 8-bit one-hot HI/LO operation field produced by ID decode, plus the two register source operands.
- Owns the architectural HI and LO registers.
- Executes mult/multu in a single cycle and div/divu iteratively (radix-2, 32 iterations).
- Stalls the pipeline through a valid/ready handshake while a divide is in flight.

Parameters:
- DIV_CYCLES, 32, number of iteration cycles per divide; fixed at 32 for the current design, and other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  EX holds a HI/LO operation this cycle
- in_ready  output  1  unit can accept the operation this cycle
- hi_lo_op  input  8  one-hot op: [0] div, [1] divu, [2] mult, [3] multu, [4] mthi, [5] mtlo, [6] mfhi, [7] mflo
- src1  input  32  rs value (dividend, multiplicand, or mthi/mtlo data)
- src2  input  32  rt value (divisor, multiplier)
- flush  input  1  exception/eret cancel from WB; kills any in-flight or offered op
- busy  output  1  divide in progress
- div_done  output  1  one-cycle pulse in the cycle HI/LO are written by a divide
- rdata  output  32  mfhi/mflo result, combinational
- hi  output  32  current HI register (debug/forwarding)
- lo  output  32  current LO register

Behaviour:
- Reset values (async, resetn=0): HI=0, LO=0, state=IDLE, busy=0, div_done=0, iteration counter=0, partial remainder=0.
- Accept rule: accept = in_valid & in_ready & ~flush & (|hi_lo_op).
  - in_ready=1 in IDLE and DONE; in_ready=0 in DIV.
  - in_valid with hi_lo_op==0 is a no-op.
- Multi-hot hi_lo_op: lowest set bit wins.
- States:
  - IDLE -> DIV on accepted div/divu.
  - DIV -> DONE after iteration 32.
  - DONE -> IDLE unconditionally. DONE also accepts a new op, so a back-to-back div goes DONE -> DIV.
  - Any state -> IDLE when flush=1.
- mult/multu:
  - 64-bit product (signed or unsigned) written at the edge ending the accept cycle: HI=product[63:32], LO=product[31:0].
  - Results are visible the next cycle.
- mthi/mtlo: HI (resp. LO) = src1 at the edge ending the accept cycle.
- mfhi/mflo:
  - rdata = current HI/LO, combinational, in the same cycle.
  - in_ready=1 in IDLE/DONE, so an mf following a mult/mt reads the updated value one cycle later with no internal bypass needed.
  - rdata=0 when no mf op is presented.
- div/divu sequencing:
  - Accept cycle t: latch |src1|, |src2| (raw values for divu), the quotient sign (src1[31]^src2[31]) and the remainder sign (src1[31]). Counter=0.
  - Cycles t+1..t+32: one restoring-division step per cycle; busy=1, in_ready=0.
  - Edge ending t+32: apply signs and write LO=quotient, HI=remainder.
  - Cycle t+33 (DONE): div_done=1, busy=0.
- Divide arithmetic rules:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu): LO=0xFFFFFFFF, HI=src1. No exception is raised.
- Flush:
  - flush during DIV aborts the divide: HI/LO are unchanged, busy=0 the next cycle, div_done is not pulsed.
  - flush in the same cycle as an offered op: the op is not accepted and there is no state change.
  - Flush has priority over accept.
- Reset mid-divide: immediate return to reset values; HI/LO=0.

Test Plan:
- mult src1=0xFFFFFFFD (-3), src2=5 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1; multu 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div src1=0xFFFFFFF9 (-7), src2=2 -> in_ready=0 for exactly 32 cycles, div_done pulse at t+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 -> LO=14, HI=2.
- Edge divides: divu 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI=0xAAAA, LO=0x5555 preloaded via mthi/mtlo; div started, flush at iteration 10 -> busy=0 next cycle, no div_done, HI=0xAAAA, LO=0x5555 unchanged.
- mthi 0x12345678 then mfhi next cycle -> rdata=0x12345678; mfhi offered during DIV -> in_ready=0, rdata sampled on acceptance equals the divide remainder.
- resetn deasserted at iteration 5 of a div -> HI=LO=0, busy=0, in_ready=1 immediately; a new mult after release completes normally.
